// File: rtl/mul_share_if.sv
// Request/response and multiplier-side bundle for the shared multiplier arbiter.
// slave  : the arbiter (consumes requests and the product, drives grants, operands, responses).
// master : the environment (compute clients plus the multiplier instance).
// Ports: req_valid/req_ready/req_a/req_b per requester, mul_a/mul_b/mul_r to the
// multiplier, resp_valid/resp_r back to the requesters, busy status.
interface mul_share_if #(
    parameter int unsigned N_REQ = 4
) ();
    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [OP_W*N_REQ-1:0] req_a;
    logic [OP_W*N_REQ-1:0] req_b;
    logic [OP_W-1:0]       mul_a;
    logic [OP_W-1:0]       mul_b;
    logic [PROD_W-1:0]     mul_r;
    logic [N_REQ-1:0]      resp_valid;
    logic [PROD_W-1:0]     resp_r;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, mul_r,
        input  req_ready, mul_a, mul_b, resp_valid, resp_r, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_r,
        output req_ready, mul_a, mul_b, resp_valid, resp_r, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined 32x32->64 multiplier
// between N_REQ requesters. Each issue is tagged with its requester ID in a
// shift register as deep as the multiplier, so the product is routed back to
// its originator exactly MUL_LATENCY cycles after the handshake.
// Ports: clk, rst_n (async, active-low); bus (mul_share_if.slave) carrying
// req_valid/req_ready/req_a/req_b, mul_a/mul_b/mul_r, resp_valid/resp_r, busy.
module mul_share_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_share_if.slave  bus
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned OP_W = 32;

    logic [ID_W-1:0]        rr_ptr;
    logic [N_REQ-1:0]       outstanding;
    logic [MUL_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [MUL_LATENCY];

    logic [N_REQ-1:0] eligible_c;
    logic [N_REQ-1:0] resp_vld_c;
    logic             grant_vld_c;
    logic [ID_W-1:0]  grant_id_c;
    logic             issue_c;
    logic [OP_W-1:0]  sel_a_c;
    logic [OP_W-1:0]  sel_b_c;

    // (base + off) mod N_REQ, valid for non-power-of-two N_REQ as well
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int unsigned s;
        s = 32'(base) + 32'(off);
        return ID_W'(s % N_REQ);
    endfunction

    // Response decode from the oldest tag stage
    always_comb begin
        resp_vld_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            resp_vld_c[i] = tag_v[MUL_LATENCY-1] && (tag_id[MUL_LATENCY-1] == ID_W'(i));
        end
    end

    // A requester may reissue in the same cycle its previous result returns
    always_comb begin
        eligible_c = bus.req_valid & (~outstanding | resp_vld_c);
    end

    // Round-robin scan from rr_ptr; walking offsets downward leaves the nearest hit
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (eligible_c[wrap_idx(rr_ptr, k)]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = wrap_idx(rr_ptr, k);
            end
        end
    end

    // Grants are suppressed while reset is asserted
    assign issue_c = grant_vld_c && rst_n;

    // Operand mux for the granted requester
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (issue_c && (grant_id_c == ID_W'(i))) begin
                sel_a_c = bus.req_a[i*OP_W +: OP_W];
                sel_b_c = bus.req_b[i*OP_W +: OP_W];
            end
        end
    end

    assign bus.req_ready  = issue_c ? (N_REQ'(1) << grant_id_c) : '0;
    assign bus.mul_a      = sel_a_c;
    assign bus.mul_b      = sel_b_c;
    assign bus.resp_valid = resp_vld_c;
    assign bus.resp_r     = bus.mul_r;
    assign bus.busy       = |tag_v;

    // Pointer, outstanding flags and tag shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            outstanding <= '0;
            tag_v       <= '0;
            for (int s = 0; s < int'(MUL_LATENCY); s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            if (issue_c) begin
                rr_ptr <= wrap_idx(grant_id_c, 1);
            end
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (issue_c && (grant_id_c == ID_W'(i))) begin
                    outstanding[i] <= 1'b1;
                end else if (resp_vld_c[i]) begin
                    outstanding[i] <= 1'b0;
                end
            end
            tag_v[0]  <= issue_c;
            tag_id[0] <= grant_id_c;
            for (int s = 1; s < int'(MUL_LATENCY); s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed table-driven bench for mul_share_arbiter with a behavioural
// fixed-latency multiplier on the far side.
module tb_mul_share_arbiter;
    localparam int unsigned N_REQ       = 4;
    localparam int unsigned MUL_LATENCY = 2;

    logic clk;
    logic rst_n;

    mul_share_if #(.N_REQ(N_REQ)) bus ();

    mul_share_arbiter #(
        .N_REQ       (N_REQ),
        .MUL_LATENCY (MUL_LATENCY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipelined multiplier model, no reset, no stall
    logic [63:0] mp [MUL_LATENCY];
    always @(posedge clk) begin
        mp[0] <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
        for (int s = 1; s < int'(MUL_LATENCY); s++) mp[s] <= mp[s-1];
    end
    assign bus.mul_r = mp[MUL_LATENCY-1];

    typedef struct {
        bit          do_reset;
        logic [3:0]  valid;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]  ready;
        logic [31:0] mul_a;
        logic [3:0]  rv;
        logic [63:0] rr;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [127:0] ops(input logic [31:0] x0, input logic [31:0] x1,
                                         input logic [31:0] x2, input logic [31:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic void add(input bit rst, input logic [3:0] v, input logic [127:0] a,
                                input logic [127:0] b, input logic [3:0] rdy, input logic [31:0] ma,
                                input logic [3:0] rv, input logic [63:0] rr, input logic bsy);
        vec_t t;
        t.do_reset = rst; t.valid = v; t.a = a; t.b = b;
        t.ready = rdy; t.mul_a = ma; t.rv = rv; t.rr = rr; t.busy = bsy;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare all observable outputs at the current (mid-cycle) time
    task automatic sample(input string tag, input logic [3:0] rdy, input logic [31:0] ma,
                          input logic [3:0] rv, input logic [63:0] rr, input logic bsy);
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'(rdy));
        chk({tag, " mul_a"}, 64'(bus.mul_a), 64'(ma));
        chk({tag, " resp_valid"}, 64'(bus.resp_valid), 64'(rv));
        chk({tag, " busy"}, 64'(bus.busy), 64'(bsy));
        if (rv != 4'd0) chk({tag, " resp_r"}, bus.resp_r, rr);
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.do_reset) do_reset();
        bus.req_valid = v.valid;
        bus.req_a = v.a;
        bus.req_b = v.b;
        @(negedge clk);
        sample($sformatf("vec%0d", idx), v.ready, v.mul_a, v.rv, v.rr, v.busy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] z, c, bb, r, s;
        z  = '0;
        c  = ops(1, 2, 3, 4);
        bb = ops(100, 100, 100, 100);
        r  = ops(0, 0, 6, 0);
        s  = ops(0, 0, 7, 0);

        // Single request, wide operands, then skip from rr_ptr=1 with only 0 and 3 valid
        add(0, 4'b0001, ops(3, 0, 0, 0), ops(5, 0, 0, 0), 4'b0001, 3, 4'b0000, 0, 0);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0001, 64'd15, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0001, ops(32'hFFFFFFFF, 0, 0, 0), ops(32'hFFFFFFFF, 0, 0, 0),
            4'b0001, 32'hFFFFFFFF, 4'b0000, 0, 0);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0001, 64'hFFFFFFFE00000001, 1);
        add(0, 4'b1001, ops(7, 0, 0, 9), ops(2, 0, 0, 4), 4'b1000, 9, 4'b0000, 0, 0);
        add(0, 4'b0001, ops(7, 0, 0, 0), ops(2, 0, 0, 0), 4'b0001, 7, 4'b0000, 0, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b1000, 64'd36, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0001, 64'd14, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0000, 0, 0);

        // Full contention, all held valid: strict rotation with outstanding gating
        add(1, 4'b1111, c, bb, 4'b0001, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, c, bb, 4'b0010, 2, 4'b0000, 0, 1);
        add(0, 4'b1111, c, bb, 4'b0100, 3, 4'b0001, 64'd100, 1);
        add(0, 4'b1111, c, bb, 4'b1000, 4, 4'b0010, 64'd200, 1);
        add(0, 4'b1111, c, bb, 4'b0001, 1, 4'b0100, 64'd300, 1);
        add(0, 4'b1111, c, bb, 4'b0010, 2, 4'b1000, 64'd400, 1);
        add(0, 4'b1111, c, bb, 4'b0100, 3, 4'b0001, 64'd100, 1);
        add(0, 4'b1111, c, bb, 4'b1000, 4, 4'b0010, 64'd200, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0100, 64'd300, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b1000, 64'd400, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0000, 0, 0);

        // Sole requester 2 held valid: reissue in its own response cycle
        add(1, 4'b0100, r, s, 4'b0100, 6, 4'b0000, 0, 0);
        add(0, 4'b0100, r, s, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b0100, r, s, 4'b0100, 6, 4'b0100, 64'd42, 1);
        add(0, 4'b0100, r, s, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b0100, r, s, 4'b0100, 6, 4'b0100, 64'd42, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0100, 64'd42, 1);
        add(0, 4'b0000, z, z, 4'b0000, 0, 4'b0000, 0, 0);

        // Outputs held quiet while in reset, even with every requester valid
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a = c;
        bus.req_b = bb;
        @(negedge clk);
        sample("in_reset", 4'b0000, 0, 4'b0000, 0, 0);
        chk("in_reset mul_b", 64'(bus.mul_b), 64'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset while requesters 0 and 1 are in flight
        do_reset();
        bus.req_valid = 4'b0011;
        bus.req_a = ops(5, 8, 0, 0);
        bus.req_b = ops(5, 8, 0, 0);
        @(negedge clk);
        sample("mid c1", 4'b0001, 5, 4'b0000, 0, 0);
        @(posedge clk);
        #1 bus.req_valid = 4'b0010;
        @(negedge clk);
        sample("mid c2", 4'b0010, 8, 4'b0000, 0, 1);
        @(posedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sample("mid rst1", 4'b0000, 0, 4'b0000, 0, 0);
        chk("mid rst1 mul_b", 64'(bus.mul_b), 64'd0);
        @(negedge clk);
        sample("mid rst2", 4'b0000, 0, 4'b0000, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        sample("post r1", 4'b0010, 8, 4'b0000, 0, 0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        sample("post r2", 4'b0000, 0, 4'b0000, 0, 1);
        @(negedge clk);
        sample("post r3", 4'b0000, 0, 4'b0010, 64'd64, 1);
        @(negedge clk);
        sample("post r4", 4'b0000, 0, 4'b0000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
